// File: rtl/day01_stream_solver.sv
// day01_stream_solver: byte-stream dial solver; DAY01_STREAM_STATS_EN adds record_count/busy_cycles
module day01_stream_solver #(
  parameter int DIAL_SIZE = 100,
  parameter int START_POS = 50,
  parameter int AMT_WIDTH = 20,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int POS_WIDTH = $clog2(DIAL_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [OUTPUT_DATA_WIDTH-1:0] part1_result,
  output logic [OUTPUT_DATA_WIDTH-1:0] part2_result,
  output logic [POS_WIDTH-1:0]         dial_pos,
  output logic                         err,
  output logic                         done
`ifdef DAY01_STREAM_STATS_EN
  ,
  output logic [OUTPUT_DATA_WIDTH-1:0] record_count,
  output logic [31:0]                  busy_cycles
`endif
);
  typedef enum logic [1:0] {PARSE, REDUCE, APPLY, DONE} state_t;
  localparam logic [AMT_WIDTH:0] DS_A = (AMT_WIDTH+1)'(DIAL_SIZE);
  localparam logic [POS_WIDTH:0] DS_P = (POS_WIDTH+1)'(DIAL_SIZE);
  state_t state, state_n;
  logic [POS_WIDTH-1:0] pos, pos_n;
  logic [AMT_WIDTH-1:0] amt, amt_n;
  logic [OUTPUT_DATA_WIDTH-1:0] p1_n, p2_n;
  logic err_n, pend, pend_n, dir, dir_n, eos, eos_n, live;
  logic acc, is_l, is_r, is_dig, is_nl, ovf, wrap;
  logic [AMT_WIDTH+3:0] amt_x;
  logic [POS_WIDTH:0] pw, rw, sum, nxt;
  assign in_ready = live && state == PARSE;
  assign done = state == DONE;
  assign dial_pos = pos;
  assign acc = in_valid && in_ready;
  assign is_l = in_data == 8'h4c;
  assign is_r = in_data == 8'h52;
  assign is_dig = in_data >= 8'h30 && in_data <= 8'h39;
  assign is_nl = in_data == 8'h0a;
  assign amt_x = {4'd0, amt} * (AMT_WIDTH+4)'(10) + (AMT_WIDTH+4)'(in_data[3:0]);
  assign ovf = |amt_x[AMT_WIDTH+3:AMT_WIDTH];
  // APPLY only ever sees amt < DIAL_SIZE, so the low bits carry the full residual
  assign pw = {1'b0, pos};
  assign rw = {1'b0, amt[POS_WIDTH-1:0]};
  assign sum = pw + rw;
  assign wrap = dir ? sum >= DS_P : (rw != '0 && pw != '0 && rw >= pw);
  assign nxt = dir ? (wrap ? sum - DS_P : sum) : (rw > pw ? pw + DS_P - rw : pw - rw);
  always_comb begin
    state_n = state;
    pos_n = pos;
    amt_n = amt;
    p1_n = part1_result;
    p2_n = part2_result;
    err_n = err;
    pend_n = pend;
    dir_n = dir;
    eos_n = eos;
    case (state)
      PARSE: if (acc) begin
        if (is_l || is_r) begin
          dir_n = is_r;
          amt_n = '0;
          pend_n = 1'b1;
          err_n = err | pend;
        end else if (is_dig) begin
          amt_n = !pend ? amt : ovf ? '1 : amt_x[AMT_WIDTH-1:0];
          err_n = err | !pend | ovf;
        end
        eos_n = in_last;
        if (pend_n && (is_nl || in_last)) state_n = {1'b0, amt_n} >= DS_A ? REDUCE : APPLY;
        else if (in_last) state_n = DONE;
      end
      REDUCE: begin
        amt_n = amt - DS_A[AMT_WIDTH-1:0];
        p2_n = part2_result + 1'b1;
        state_n = {1'b0, amt_n} >= DS_A ? REDUCE : APPLY;
      end
      APPLY: begin
        pos_n = nxt[POS_WIDTH-1:0];
        p2_n = part2_result + OUTPUT_DATA_WIDTH'(wrap);
        p1_n = part1_result + OUTPUT_DATA_WIDTH'(nxt == '0);
        pend_n = 1'b0;
        state_n = eos ? DONE : PARSE;
      end
      DONE: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PARSE;
      pos <= POS_WIDTH'(START_POS);
      amt <= '0;
      part1_result <= '0;
      part2_result <= '0;
      err <= 1'b0;
      pend <= 1'b0;
      dir <= 1'b0;
      eos <= 1'b0;
      live <= 1'b0;
    end else begin
      state <= state_n;
      pos <= pos_n;
      amt <= amt_n;
      part1_result <= p1_n;
      part2_result <= p2_n;
      err <= err_n;
      pend <= pend_n;
      dir <= dir_n;
      eos <= eos_n;
      live <= 1'b1;
    end
  end
`ifdef DAY01_STREAM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      record_count <= '0;
      busy_cycles <= '0;
    end else begin
      record_count <= record_count + OUTPUT_DATA_WIDTH'(state == APPLY);
      busy_cycles <= busy_cycles + 32'(state != DONE);
    end
  end
`endif
endmodule

// File: tb/tb_day01_stream_solver.sv
// tb_day01_stream_solver: randomized scoreboard bench, two dial geometries
module tb_day01_stream_solver;
  typedef struct {int pos; int p1; int p2; int err; int dn; int lat;} ent_t;
  localparam longint AMAX = (64'd1 << 20) - 1;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] in_data [2];
  logic in_valid [2], in_last [2], in_ready [2], err [2], done [2];
  logic [15:0] p1 [2], p2 [2];
  logic [6:0] pos [2];
`ifdef DAY01_STREAM_STATS_EN
  logic [15:0] rc [2];
  logic [31:0] bc [2];
`endif
  ent_t q [2][$];
  ent_t e;
  int total = 0, bad = 0, rreq = 0, fin = 0;
  int rdone [2], lat [2], fdone [2];
  bit armed [2], pr [2], pd [2];
  int ds [2] = '{100, 7};
  int sp [2] = '{50, 3};
  longint mpos [2], mp1 [2], mp2 [2], mamt [2];
  bit merr [2], mpend [2], mdir [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    day01_stream_solver #(.DIAL_SIZE(g == 0 ? 100 : 7), .START_POS(g == 0 ? 50 : 3), .POS_WIDTH(7)) dut (
      .clk(clk), .rst(rst), .in_data(in_data[g]), .in_valid(in_valid[g]), .in_last(in_last[g]),
      .in_ready(in_ready[g]), .part1_result(p1[g]), .part2_result(p2[g]), .dial_pos(pos[g]),
      .err(err[g]), .done(done[g])
`ifdef DAY01_STREAM_STATS_EN
      , .record_count(rc[g]), .busy_cycles(bc[g])
`endif
    );
  end

  function automatic void chk(string nm, int i, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, i, act, exp);
    end
  endfunction

  // Monitor: compares on record completion (ready returns) and on done rising
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        if (rdone[i] != rreq) begin
          rdone[i] = rreq;
          chk("rst_pos", i, pos[i], sp[i]);
          chk("rst_part1", i, p1[i], 0);
          chk("rst_part2", i, p2[i], 0);
          chk("rst_err", i, err[i], 0);
          chk("rst_done", i, done[i], 0);
          chk("rst_ready", i, in_ready[i], 0);
        end
        armed[i] = 0; pr[i] = 0; pd[i] = 0; lat[i] = 0;
      end else begin
        lat[i]++;
        if ((armed[i] && in_ready[i] && !pr[i]) || (done[i] && !pd[i])) begin
          chk("event_expected", i, q[i].size() > 0, 1);
          if (q[i].size() > 0) begin
            e = q[i].pop_front();
            chk("pos", i, pos[i], e.pos);
            chk("part1", i, p1[i], e.p1);
            chk("part2", i, p2[i], e.p2);
            chk("err", i, err[i], e.err);
            chk("done", i, done[i], e.dn);
            chk("busy_cycles", i, lat[i] - 1, e.lat);
          end
        end
        if (in_valid[i] && in_ready[i]) begin
          lat[i] = 0;
          armed[i] = 1;
        end
        pr[i] = in_ready[i];
        pd[i] = done[i];
      end
      if (fin != 0 && fdone[i] == 0) begin
        fdone[i] = 1;
        chk("leftover", i, q[i].size(), 0);
      end
    end
  end

  task automatic model_reset(int i);
    mpos[i] = sp[i]; mp1[i] = 0; mp2[i] = 0; mamt[i] = 0;
    merr[i] = 0; mpend[i] = 0; mdir[i] = 0;
  endtask

  task automatic push(int i, int dn, int l);
    ent_t x;
    x.pos = int'(mpos[i]); x.p1 = int'(mp1[i] % 65536); x.p2 = int'(mp2[i] % 65536);
    x.err = int'(merr[i]); x.dn = dn; x.lat = l;
    q[i].push_back(x);
  endtask

  task automatic model_byte(int i, logic [7:0] b, bit last);
    longint p, a, d;
    int l;
    if (b == "L" || b == "R") begin
      if (mpend[i]) merr[i] = 1;
      mdir[i] = (b == "R"); mamt[i] = 0; mpend[i] = 1;
    end else if (b >= "0" && b <= "9") begin
      if (!mpend[i]) merr[i] = 1;
      else begin
        mamt[i] = mamt[i] * 10 + longint'(b - "0");
        if (mamt[i] > AMAX) begin mamt[i] = AMAX; merr[i] = 1; end
      end
    end
    if (mpend[i] && (b == 8'h0a || last)) begin
      p = mpos[i]; a = mamt[i]; d = ds[i];
      l = int'(a / d) + 1;
      if (mdir[i]) begin
        mp2[i] += (p + a) / d;
        p = (p + a) % d;
      end else begin
        mp2[i] += (p == 0) ? a / d : (a >= p ? (a - p) / d + 1 : 0);
        p = ((p - a) % d + d) % d;
      end
      mpos[i] = p;
      if (p == 0) mp1[i]++;
      mpend[i] = 0;
      push(i, last, l);
    end else if (last) push(i, 1, 0);
  endtask

  task automatic send(int i, string s);
    int n;
    logic [7:0] b;
    bit lst;
    for (int k = 0; k < s.len(); k++) begin
      b = s[k];
      lst = (k == s.len() - 1);
      in_valid[i] = 0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      in_data[i] = b; in_last[i] = lst; in_valid[i] = 1;
      model_byte(i, b, lst);
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n > 30000) begin
          $display("FAIL handshake[%0d]: byte %0d never accepted", i, k);
          $fatal(1);
        end
      end while (!in_ready[i]);
      @(posedge clk);
      #1;
    end
    in_valid[i] = 0;
    in_last[i] = 0;
  endtask

  task automatic wait_done(int i);
    int n = 0;
    while (!done[i]) begin
      @(negedge clk);
      n++;
      if (n > 30000) begin
        $display("FAIL done_timeout[%0d]: done=0 required 1", i);
        $fatal(1);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 0; in_last[i] = 0;
      q[i].delete();
      model_reset(i);
    end
    rreq++;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1;
  endtask

  function automatic string rand_stream(int n, bit big);
    string s = "";
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 1) == 1) s = {s, "R"};
      else s = {s, "L"};
      s = {s, $sformatf("%0d", $urandom_range(0, 350))};
      if ($urandom_range(0, 3) == 0) s = {s, "\015"};
      s = {s, "\n"};
      if ($urandom_range(0, 7) == 0) s = {s, " "};
    end
    if (big) s = {s, "R12345678\n"};
    if ($urandom_range(0, 1) == 1) s = {s, "L7\n"};
    else s = {s, "\015"};
    return s;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 0; in_last[i] = 0; in_data[i] = 0;
      rdone[i] = 0; fdone[i] = 0; lat[i] = 0;
      model_reset(i);
    end
    do_reset();
    send(0, "L68\nL30\nR48\nL5\nR60\nL55\nL1\nL99\nR14\nL82\n");
    wait_done(0);
    do_reset();
    send(0, "R1000");
    wait_done(0);
    do_reset();
    send(0, "L50\nR0\nL100\n");
    wait_done(0);
    do_reset();
    send(0, "5\nLL3\015\nR2\n");
    wait_done(0);
    do_reset();
    send(1, "L10\nR4\n");
    wait_done(1);
    do_reset();
    send(0, "R999999");
    repeat (40) @(posedge clk);
    do_reset();
    send(0, "R999999");
    wait_done(0);
    do_reset();
    send(0, rand_stream(60, 1));
    wait_done(0);
    send(1, rand_stream(40, 0));
    wait_done(1);
    fin = 1;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/day01_stream_solver.md
Name: day01_stream_solver

Overview:
- Parametrised successor to the day-1 dial solver core.
- Consumes the puzzle text as an ASCII byte stream over a valid/ready handshake instead of addressing a ROM.
- Supports arbitrary dial size and start position, unbounded-size rotations via multi-cycle full-turn reduction, and malformed-input flagging.
- Sits between any byte source (ROM reader, UART RX FIFO) and the result registers read by the bench.

Parameters:
- DIAL_SIZE, 100: number of dial positions; must be ≥ 2.
- START_POS, 50: dial position after reset; must be < DIAL_SIZE.
- AMT_WIDTH, 20: width of the parsed rotation-amount accumulator.
- OUTPUT_DATA_WIDTH, 16: width of the result counters.
- POS_WIDTH, $clog2(DIAL_SIZE): width of the position register (derived).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  8  ASCII byte.
- in_valid  in  1  in_data is valid.
- in_last  in  1  qualifies the final byte of the stream.
- in_ready  out  1  solver accepts a byte this cycle.
- part1_result  out  OUTPUT_DATA_WIDTH  count of records that end at position 0.
- part2_result  out  OUTPUT_DATA_WIDTH  count of clicks that land on position 0.
- dial_pos  out  POS_WIDTH  current dial position.
- err  out  1  sticky malformed-input or overflow flag.
- done  out  1  results final; held until reset.

Behaviour:
- Reset (rst low, async): pos=START_POS; part1_result, part2_result, err, done, amt, pending, dir = 0; in_ready=0; state=PARSE. in_ready goes high on the first clock after release.
- Transfer occurs when in_valid && in_ready. Bytes presented while in_ready=0 are held by the source, not dropped.
- States: PARSE, REDUCE, APPLY, DONE.
- PARSE (in_ready=1), on an accepted byte:
  - 'L' (0x4C) or 'R' (0x52): set dir, amt=0, pending=1. If a record was already pending, discard it and set err.
  - '0'-'9': if pending, amt = amt*10 + digit. If the result exceeds 2^AMT_WIDTH-1, saturate amt and set err. If not pending, ignore the digit and set err.
  - 0x0A: if pending, go to REDUCE; otherwise ignore.
  - 0x0D and any other byte: ignored.
  - in_last on the accepted byte: process the byte as above, then terminate the record if pending (go to REDUCE), else go to DONE. The end-of-stream condition is latched.
- REDUCE (in_ready=0): while amt ≥ DIAL_SIZE: amt -= DIAL_SIZE and part2 += 1, one subtraction per cycle. When amt < DIAL_SIZE, go to APPLY. Latency is floor(amt/DIAL_SIZE) cycles.
- APPLY (in_ready=0, one cycle), with r = amt:
  - R: t = pos + r. If t ≥ DIAL_SIZE: pos = t - DIAL_SIZE and part2 += 1; else pos = t.
  - L, r = 0: no change.
  - L, pos = 0, r > 0: pos = DIAL_SIZE - r; no part2 increment.
  - L, r ≥ pos > 0: pos = pos - r (+DIAL_SIZE if negative) and part2 += 1.
  - L, r < pos: pos = pos - r.
  - After the update, if the new pos = 0: part1 += 1. A zero-amount record starting at 0 therefore counts toward part1.
  - Clear pending. Go to DONE if the end-of-stream condition is latched, else PARSE.
  - Part2 increments from REDUCE and APPLY in the same record accumulate. Part2 may add 1 in APPLY in the same cycle part1 adds 1.
- Per-record latency from terminator acceptance back to in_ready=1: floor(amt/DIAL_SIZE)+1 cycles.
- DONE: in_ready=0 and done=1, held until reset. Outputs are frozen.
- Counters wrap modulo 2^OUTPUT_DATA_WIDTH; there is no saturation.
- Reset asserted mid-REDUCE or mid-record discards all progress immediately.

Optional Feature:
- Macro DAY01_STREAM_STATS_EN.
- When defined: adds output record_count [OUTPUT_DATA_WIDTH-1:0], incremented once per APPLY, and output busy_cycles [31:0], counting clocks from reset release until done rises. Both reset to 0 and freeze at done.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- AoC example "L68\nL30\nR48\nL5\nR60\nL55\nL1\nL99\nR14\nL82\n" with in_last on the final byte, defaults -> part1=3, part2=6, dial_pos=32, err=0, done=1.
- "R1000" (in_last on '0'), no newline -> part2=10, part1=0, dial_pos=50. in_ready is low for exactly 11 cycles after the last byte.
- "L50\nR0\nL100\n" -> dial_pos=0, part1=3, part2=2 (L50 lands on 0; R0 stays at 0; L100 from 0 is one full turn).
- Malformed input "5\nLL3\r\nR2\n" -> err=1, dial_pos=49, part1=0. '5' and the first L are discarded, CR is ignored.
- DIAL_SIZE=7, START_POS=3, "L10\nR4\n" -> after L10: pos=0, part1=1, part2=2; after R4: pos=4, part1=1, part2=2.
- Backpressure and reset: hold in_valid through busy cycles and confirm no byte is lost. Pulse rst low during REDUCE of "R999999" -> all outputs return to reset values asynchronously; the stream replayed afterwards gives the same results as a clean run.
